// File: rtl/alu_pkg.sv
// alu_pkg: shared command encodings and default datapath width for the ALU.
package alu_pkg;
    localparam int WIDTH_DEF = 8;
    typedef enum logic [2:0] {
        ADD = 3'b000,
        LSL = 3'b001,
        LSR = 3'b010,
        AND = 3'b011,
        OR  = 3'b100,
        XOR = 3'b101,
        SUB = 3'b110,
        CMP = 3'b111
    } alu_cmd_e;
endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational op decode producing the next result and status flag.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2:0]       alu_cmd,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic [WIDTH-1:0] next_rslt,
    output logic             next_flag
);
    logic [WIDTH:0] sum, diff, shl, shr;
    always_comb begin
        sum  = {1'b0, inA} + {1'b0, inB};
        diff = {1'b0, inA} - {1'b0, inB};
        // A guard bit beside the operand catches the last bit shifted out; it stays 0 for zero or oversized shifts.
        shl  = {1'b0, inA} << inB;
        shr  = {inA, 1'b0} >> inB;
        next_rslt = '0;
        next_flag = 1'b0;
        case (alu_cmd_e'(alu_cmd))
            ADD: {next_flag, next_rslt} = sum;
            LSL: {next_flag, next_rslt} = shl;
            LSR: {next_rslt, next_flag} = shr;
            AND: begin
                next_rslt = inA & inB;
                next_flag = next_rslt == '0;
            end
            OR: begin
                next_rslt = inA | inB;
                next_flag = next_rslt == '0;
            end
            XOR: begin
                next_rslt = inA ^ inB;
                next_flag = next_rslt == '0;
            end
            SUB: {next_flag, next_rslt} = diff;
            CMP: begin
                next_rslt = diff[WIDTH-1:0];
                next_flag = inA == inB;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_unit.sv
// alu_unit: 8-bit datapath ALU with registered result and flag, async active-low reset.
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       alu_cmd,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic [WIDTH-1:0] rslt,
    output logic             flag
);
    logic [WIDTH-1:0] rslt_d, rslt_q;
    logic             flag_d, flag_q;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .alu_cmd   (alu_cmd),
        .inA       (inA),
        .inB       (inB),
        .next_rslt (rslt_d),
        .next_flag (flag_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rslt_q <= '0;
            flag_q <= 1'b0;
        end else begin
            rslt_q <= rslt_d;
            flag_q <= flag_d;
        end
    end

    assign rslt = rslt_q;
    assign flag = flag_q;
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and randomized checks of alu_unit against an arithmetic reference model.
module tb_alu_unit;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] alu_cmd = '0;
    logic [7:0] inA = '0, inB = '0;
    logic [7:0] rslt;
    logic       flag;
    int         n_assert = 0, n_fail = 0;
    logic [8:0] q[$];

    always #5 clk = ~clk;

    alu_unit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .alu_cmd (alu_cmd),
        .inA     (inA),
        .inB     (inB),
        .rslt    (rslt),
        .flag    (flag)
    );

    // Returns {flag, rslt} computed from the command rules with integer arithmetic.
    function automatic logic [8:0] model(input int c, input int a, input int b);
        int r = 0;
        bit f = 1'b0;
        case (c)
            0: begin r = a + b; f = r > 255; end
            1: if (b == 0) r = a;
               else if (b <= 8) begin r = a * (1 << b); f = ((a >> (8 - b)) % 2) == 1; end
            2: if (b <= 8) begin r = a / (1 << b); f = (b > 0) && (((a >> (b - 1)) % 2) == 1); end
            3: begin r = a & b; f = r == 0; end
            4: begin r = a | b; f = r == 0; end
            5: begin r = a ^ b; f = r == 0; end
            6: begin r = a - b; f = a < b; end
            7: begin r = a - b; f = a == b; end
            default: ;
        endcase
        return {f, 8'(r & 255)};
    endfunction

    task automatic check(input string tag, input logic [7:0] er, input logic ef);
        n_assert++;
        assert (rslt === er) else begin
            n_fail++;
            $error("FAIL %s rslt got %0h expected %0h", tag, rslt, er);
        end
        n_assert++;
        assert (flag === ef) else begin
            n_fail++;
            $error("FAIL %s flag got %0b expected %0b", tag, flag, ef);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] c, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic ef);
        @(negedge clk);
        alu_cmd = c; inA = a; inB = b;
        @(posedge clk);
        #1;
        check(tag, er, ef);
    endtask

    initial begin
        logic [8:0] e;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        step("add_5_6",    ADD, 8'd5,   8'd6,   8'd11,  1'b0);
        step("add_0_20",   ADD, 8'd0,   8'd20,  8'd20,  1'b0);
        step("add_carry",  ADD, 8'd200, 8'd100, 8'd44,  1'b1);
        step("sub_3_6",    SUB, 8'd3,   8'd6,   8'd253, 1'b1);
        step("sub_8_6",    SUB, 8'd8,   8'd6,   8'd2,   1'b0);
        step("cmp_3_2",    CMP, 8'd3,   8'd2,   8'd1,   1'b0);
        step("cmp_4_4",    CMP, 8'd4,   8'd4,   8'd0,   1'b1);
        step("lsl_80_1",   LSL, 8'h80,  8'd1,   8'h00,  1'b1);
        step("lsl_80_3",   LSL, 8'h80,  8'd3,   8'h00,  1'b0);
        step("lsl_b0",     LSL, 8'h5A,  8'd0,   8'h5A,  1'b0);
        step("lsl_b8",     LSL, 8'h01,  8'd8,   8'h00,  1'b1);
        step("lsl_b9",     LSL, 8'hFF,  8'd9,   8'h00,  1'b0);
        step("lsr_81_1",   LSR, 8'h81,  8'd1,   8'h40,  1'b1);
        step("lsr_b0",     LSR, 8'hC3,  8'd0,   8'hC3,  1'b0);
        step("lsr_b8",     LSR, 8'h80,  8'd8,   8'h00,  1'b1);
        step("lsr_b9",     LSR, 8'hFF,  8'd9,   8'h00,  1'b0);
        step("and_f0_0f",  AND, 8'hF0,  8'h0F,  8'h00,  1'b1);
        step("or_f0_0f",   OR,  8'hF0,  8'h0F,  8'hFF,  1'b0);
        step("xor_aa_aa",  XOR, 8'hAA,  8'hAA,  8'h00,  1'b1);

        step("pre_reset",  ADD, 8'd200, 8'd100, 8'd44,  1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check("reset_hold", 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_edge", 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check("release_edge", 8'd44, 1'b1);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            alu_cmd = 3'(i);
            inA = 8'($urandom);
            inB = (i == 1 || i == 2) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            q.push_back(model(i, int'(inA), int'(inB)));
            @(posedge clk);
            #1;
            e = q.pop_front();
            check($sformatf("b2b_%0d", i), e[7:0], e[8]);
        end

        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            alu_cmd = 3'($urandom);
            inA = 8'($urandom);
            inB = $urandom_range(0, 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            e = model(int'(alu_cmd), int'(inA), int'(inB));
            @(posedge clk);
            #1;
            check($sformatf("rand_%0d_cmd%0d_%0h_%0h", i, alu_cmd, inA, inB), e[7:0], e[8]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
